// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronizes the serial line, frames start/data/stop
// bits on a half-bit tick grid, and hands received bytes to a valid/ack consumer.
module uart_rx_sequencer #(
    parameter int unsigned HALF_BAUD = 217,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CntW = (HALF_BAUD > 1) ? $clog2(HALF_BAUD) : 1;
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] CntMax  = CntW'(HALF_BAUD - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, sync2_q, rx_prev_q;
    logic                   rx_s;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   phase_q, phase_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   half_tick;
    logic                   done;
    logic                   bad_stop;

    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q;

    assign rx_s      = sync2_q;
    assign half_tick = (cnt_q == CntMax);

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // Frame FSM next state, half-tick counter and bit sampling.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        done     = 1'b0;
        bad_stop = 1'b0;

        case (state_q)
            StIdle: begin
                // Requires a true falling edge so a stuck-low line cannot retrigger.
                if (!rx_s && rx_prev_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (half_tick) begin
                    idx_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (half_tick) begin
                    phase_d = !phase_q;
                    // Second half-tick of a bit lands on the bit centre.
                    if (phase_q) begin
                        shift_d[idx_q] = rx_s;
                        if (idx_q == IdxLast) begin
                            state_d = StStop;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end
            end
            StStop: begin
                if (half_tick) begin
                    phase_d = !phase_q;
                    if (phase_q) begin
                        state_d = StIdle;
                        if (rx_s) begin
                            done = 1'b1;
                        end else begin
                            bad_stop = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every state starts on a fresh half-period.
        if (state_q == StIdle || state_d != state_q) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            cnt_d = half_tick ? '0 : cnt_q + CntW'(1);
        end
    end

    // Consumer handshake: completion wins over ack, ack clears overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (done) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !rx_ack;
        end
    end

    // Sequencer and output state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= bad_stop;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule
